// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch path: NOP word, reset PC, fetch FSM encoding, IF/ID layout.
package mips_pkg;
  localparam int          INSTR_W      = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc4;
    logic               valid;
  } ifid_t;
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready handshake between the fetch stage (master) and imem (slave).
interface fetch_stage_if;
  import mips_pkg::*;
  logic               req;
  logic [31:0]        addr;
  logic               ready;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, addr, input ready, rdata);
  modport slave  (input req, addr, output ready, rdata);
endinterface

// File: rtl/fetch_stage_if_id.sv
// IF/ID pipeline register: 65-bit {instr, pc4, valid} with flush (bubble) taking priority over load.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_INSTR
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  flush,
  input  ifid_t d,
  output ifid_t q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     q <= '{instr: NOP, pc4: 32'h0, valid: 1'b0};
    else if (flush) q <= '{instr: NOP, pc4: 32'h0, valid: 1'b0};
    else if (load)  q <= d;
  end
endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction fetch + IF/ID register with stall, redirect and a 1-entry pending buffer.
// Optional perf counters (fetch_cnt, flush_cnt) when FETCH_PERF_EN is defined.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  fetch_stage_if.master      imem,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [31:0]        ifid_pc4,
  output logic               ifid_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        flush_cnt
`endif
);
  fetch_state_t       state, state_n;
  logic [31:0]        pc, pc_n, pc4;
  logic [INSTR_W-1:0] pend_instr;
  logic [31:0]        pend_pc4;
  logic               pend_load, fire;
  logic               ifid_load, ifid_flush;
  ifid_t              ifid_d, ifid_q;

  assign pc4       = pc + 32'd4;
  assign imem.req  = (state == ST_FETCH);
  assign imem.addr = pc;
  assign fire      = imem.req & imem.ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_BOOT;
      pc         <= RESET_PC;
      pend_instr <= NOP_INSTR;
      pend_pc4   <= 32'h0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      if (pend_load) begin
        pend_instr <= imem.rdata;
        pend_pc4   <= pc4;
      end
    end
  end

  // Redirect overrides everything, even a stall: the pending word and any
  // same-cycle fetch belong to the wrong path and are simply dropped.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    pend_load  = 1'b0;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ifid_d     = '{instr: imem.rdata, pc4: pc4, valid: 1'b1};
    if (redirect) begin
      pc_n       = redirect_pc & ~32'h3;
      ifid_flush = 1'b1;
      state_n    = ST_FETCH;
    end else begin
      case (state)
        ST_BOOT: state_n = ST_FETCH;
        ST_FETCH: begin
          if (stall) begin
            if (fire) begin
              pend_load = 1'b1;
              pc_n      = pc4;
              state_n   = ST_HOLD;
            end
          end else if (fire) begin
            ifid_load = 1'b1;
            pc_n      = pc4;
          end else begin
            ifid_flush = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            ifid_d    = '{instr: pend_instr, pc4: pend_pc4, valid: 1'b1};
            ifid_load = 1'b1;
            state_n   = ST_FETCH;
          end
        end
        default: state_n = ST_BOOT;
      endcase
    end
  end

  if_id_reg #(.NOP(NOP_INSTR)) u_if_id (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ifid_load),
    .flush (ifid_flush),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign ifid_instr = ifid_q.instr;
  assign ifid_pc4   = ifid_q.pc4;
  assign ifid_valid = ifid_q.valid;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= 32'h0;
      flush_cnt <= 32'h0;
    end else begin
      if (ifid_load && ifid_d.valid) fetch_cnt <= fetch_cnt + 32'd1;
      if (redirect)                  flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif
endmodule
